// File: rtl/fma_flags_pipe_if.sv
// Handshake and operand bundle for the FMA special-case / flag resolution stage.
// The master drives the operation and the downstream ready; the slave is the stage itself.
interface fma_flags_pipe_if #(
    parameter int NE = 5,
    parameter int NF = 10
);
    localparam int W = NE + NF + 1;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  z;
    logic          xs;
    logic          ys;
    logic          zs;
    logic [2:0]    snan;
    logic [2:0]    nan;
    logic [2:0]    inf;
    logic [2:0]    zero;
    logic [1:0]    roundmode;
    logic          sticky;
    logic          guard;
    logic          rnd;
    logic [NE+1:0] senorm;
    logic [W-1:0]  mid_result;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_flags;
    logic          flags_clr;
    logic [3:0]    acc_flags;

    modport master (
        output in_valid, x, y, z, xs, ys, zs, snan, nan, inf, zero, roundmode,
               sticky, guard, rnd, senorm, mid_result, out_ready, flags_clr,
        input  in_ready, out_valid, out_result, out_flags, acc_flags
    );

    modport slave (
        input  in_valid, x, y, z, xs, ys, zs, snan, nan, inf, zero, roundmode,
               sticky, guard, rnd, senorm, mid_result, out_ready, flags_clr,
        output in_ready, out_valid, out_result, out_flags, acc_flags
    );
endinterface

// File: rtl/fma_flags_pipe.sv
// FMA special-case override and IEEE flag generation, one register stage with valid/ready,
// plus sticky accumulated flags. Define FMA_FLAGS_NAN_PROPAGATE_EN to propagate NaN payloads.
module fma_flags_pipe #(
    parameter int NE = 5,
    parameter int NF = 10
) (
    input logic          clk,
    input logic          reset,
    fma_flags_pipe_if.slave bus
);
    localparam int W = NE + NF + 1;

    localparam logic [1:0]    RM_RZ     = 2'b00;
    localparam logic [1:0]    RM_RNE    = 2'b01;
    localparam logic [1:0]    RM_RDN    = 2'b10;
    localparam logic [1:0]    RM_RUP    = 2'b11;
    localparam logic [W-1:0]  QNAN      = {1'b0, {NE{1'b1}}, 1'b1, {(NF-1){1'b0}}};
    localparam logic [NE:0]   OVF_LIMIT = {1'b0, {NE{1'b1}}};
    localparam logic [NE+1:0] SEN_ZERO  = {(NE+2){1'b0}};
    localparam logic [3:0]    FLAGS_NONE = 4'b0000;

    typedef enum logic [2:0] {
        RES_SNAN,
        RES_QNAN,
        RES_INF_SUB,
        RES_INF_ZERO,
        RES_INF_PROD,
        RES_INF_ADDEND,
        RES_OVERFLOW,
        RES_FINITE
    } resolve_t;

    function automatic logic [W-1:0] inf_word(input logic s);
        return {s, {NE{1'b1}}, {NF{1'b0}}};
    endfunction

    function automatic logic [W-1:0] max_finite(input logic s);
        return {s, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
    endfunction

    // Overflow saturates to infinity only when rounding points away from zero.
    function automatic logic ovf_to_inf(input logic [1:0] rm, input logic s);
        logic r;
        case (rm)
            RM_RZ:   r = 1'b0;
            RM_RNE:  r = 1'b1;
            RM_RDN:  r = s;
            RM_RUP:  r = ~s;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

`ifdef FMA_FLAGS_NAN_PROPAGATE_EN
    function automatic logic [W-1:0] quieten(input logic [W-1:0] v);
        logic [W-1:0] q;
        q = v;
        q[NF-1] = 1'b1;
        return q;
    endfunction

    // First NaN operand in X, Y, Z order keeps sign and payload.
    function automatic logic [W-1:0] first_nan(input logic [2:0] is_nan, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r;
        if (is_nan[2]) begin
            r = quieten(a);
        end else if (is_nan[1]) begin
            r = quieten(b);
        end else if (is_nan[0]) begin
            r = quieten(c);
        end else begin
            r = QNAN;
        end
        return r;
    endfunction
`endif

    logic          any_snan_s;
    logic          any_nan_s;
    logic          any_inf_s;
    logic          grs_s;
    logic          eff_sub_s;
    logic          ovf_s;
    logic          sen_le0_s;
    logic          mid_sign_s;
    logic [W-1:0]  nan_res_s;
    resolve_t      kind_s;
    logic [W-1:0]  res_s;
    logic          nv_s;
    logic          of_s;
    logic          uf_s;
    logic          nx_s;
    logic [3:0]    flags_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          fire_s;
    logic [3:0]    acc_next_s;
    logic          unused_s;

    logic          out_valid_r;
    logic [W-1:0]  out_result_r;
    logic [3:0]    out_flags_r;
    logic [3:0]    acc_flags_r;

    assign any_snan_s = |bus.snan;
    assign any_nan_s  = |bus.nan;
    assign any_inf_s  = |bus.inf;
    assign grs_s      = bus.sticky | bus.guard | bus.rnd;
    assign eff_sub_s  = bus.xs ^ bus.ys ^ bus.zs;
    assign mid_sign_s = bus.mid_result[W-1];
    assign ovf_s      = (bus.senorm[NE+1] == 1'b0) && (bus.senorm[NE:0] >= OVF_LIMIT);
    assign sen_le0_s  = bus.senorm[NE+1] | (bus.senorm == SEN_ZERO);

`ifdef FMA_FLAGS_NAN_PROPAGATE_EN
    assign nan_res_s = first_nan(bus.snan | bus.nan, bus.x, bus.y, bus.z);
    assign unused_s  = bus.zero[0];
`else
    assign nan_res_s = QNAN;
    assign unused_s  = bus.zero[0] ^ (^bus.x) ^ (^bus.y) ^ (^bus.z);
`endif

    // Classify the operation by the first matching special case.
    always_comb begin
        kind_s = RES_FINITE;
        if (any_snan_s) begin
            kind_s = RES_SNAN;
        end else if (any_nan_s) begin
            kind_s = RES_QNAN;
        end else if ((bus.inf[2] | bus.inf[1]) & bus.inf[0] & eff_sub_s) begin
            kind_s = RES_INF_SUB;
        end else if ((bus.inf[2] & bus.zero[1]) | (bus.zero[2] & bus.inf[1])) begin
            kind_s = RES_INF_ZERO;
        end else if (bus.inf[2] | bus.inf[1]) begin
            kind_s = RES_INF_PROD;
        end else if (bus.inf[0]) begin
            kind_s = RES_INF_ADDEND;
        end else if (ovf_s) begin
            kind_s = RES_OVERFLOW;
        end else begin
            kind_s = RES_FINITE;
        end
    end

    // Resolve the result word and the invalid/overflow flags for the chosen case.
    always_comb begin
        res_s = bus.mid_result;
        nv_s  = 1'b0;
        of_s  = 1'b0;
        case (kind_s)
            RES_SNAN: begin
                res_s = nan_res_s;
                nv_s  = 1'b1;
            end
            RES_QNAN: begin
                res_s = nan_res_s;
            end
            RES_INF_SUB, RES_INF_ZERO: begin
                res_s = QNAN;
                nv_s  = 1'b1;
            end
            RES_INF_PROD: begin
                res_s = inf_word(bus.xs ^ bus.ys);
            end
            RES_INF_ADDEND: begin
                res_s = inf_word(bus.zs);
            end
            RES_OVERFLOW: begin
                res_s = ovf_to_inf(bus.roundmode, mid_sign_s) ? inf_word(mid_sign_s)
                                                              : max_finite(mid_sign_s);
                of_s  = 1'b1;
            end
            RES_FINITE: begin
                res_s = bus.mid_result;
            end
            default: begin
                res_s = QNAN;
                nv_s  = 1'b1;
            end
        endcase
    end

    // Inexact is suppressed whenever the result comes from an infinity, a NaN or an invalid op.
    always_comb begin
        uf_s    = (kind_s == RES_FINITE) & sen_le0_s & grs_s;
        nx_s    = (grs_s | of_s) & ~(any_inf_s | any_nan_s | nv_s);
        flags_s = {nv_s, of_s, uf_s, nx_s};
    end

    assign in_ready_s = ~out_valid_r | bus.out_ready;
    assign accept_s   = bus.in_valid & in_ready_s;
    assign fire_s     = out_valid_r & bus.out_ready;

    // Flags accumulate on delivery; a firing result survives a same-cycle clear.
    always_comb begin
        acc_next_s = (bus.flags_clr ? FLAGS_NONE : acc_flags_r) | (fire_s ? out_flags_r : FLAGS_NONE);
    end

    // Output stage and flag accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {W{1'b0}};
            out_flags_r  <= FLAGS_NONE;
            acc_flags_r  <= FLAGS_NONE;
        end else begin
            if (in_ready_s) begin
                out_valid_r <= bus.in_valid;
            end
            if (accept_s) begin
                out_result_r <= res_s;
                out_flags_r  <= flags_s;
            end
            acc_flags_r <= acc_next_s;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = out_result_r;
    assign bus.out_flags  = out_flags_r;
    assign bus.acc_flags  = acc_flags_r;
endmodule

// File: tb/tb_fma_flags_pipe.sv
// Directed self-checking bench for fma_flags_pipe (binary16), special cases, rounding
// on overflow, underflow flags, back-pressure, flag accumulation and reset.
module tb_fma_flags_pipe;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fma_flags_pipe_if #(.NE(5), .NF(10)) bus ();

    fma_flags_pipe #(.NE(5), .NF(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FMA_FLAGS_NAN_PROPAGATE_EN
    localparam logic [15:0] EXP_SNAN = 16'h7f00;
    localparam logic [15:0] EXP_QNAN = 16'hfe01;
`else
    localparam logic [15:0] EXP_SNAN = 16'h7e00;
    localparam logic [15:0] EXP_QNAN = 16'h7e00;
`endif

    typedef struct packed {
        logic [15:0] x, y, z;
        logic [2:0]  sgn, c_snan, c_nan, c_inf, c_zero;
        logic [1:0]  rm;
        logic [2:0]  sgr;
        logic [6:0]  sen;
        logic [15:0] mid, exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.x = v.x; bus.y = v.y; bus.z = v.z;
        {bus.xs, bus.ys, bus.zs} = v.sgn;
        bus.snan = v.c_snan; bus.nan = v.c_nan; bus.inf = v.c_inf; bus.zero = v.c_zero;
        bus.roundmode = v.rm;
        {bus.sticky, bus.guard, bus.rnd} = v.sgr;
        bus.senorm = v.sen;
        bus.mid_result = v.mid;
    endtask

    task automatic send();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply('0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flags_clr = 1'b0;
        do_reset();
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.out_result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", bus.out_result); end
        checks++;
        if (bus.out_flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", bus.out_flags); end
        checks++;
        if (bus.acc_flags !== 4'b0000) begin errors++; $display("FAIL reset_acc got %b exp 0000", bus.acc_flags); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++;
    endtask

    task automatic test_special();
        vec_t v[$];
        // x, y, z, sgn, snan, nan, inf, zero, rm, sgr, sen, mid, exp_res, exp_flags
        v.push_back('{16'h7d00, 16'h3c00, 16'h0000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001, 2'b01, 3'b000, 7'd0, 16'h0000, EXP_SNAN, 4'b1000});
        v.push_back('{16'h3c00, 16'hfe01, 16'h3c00, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 2'b01, 3'b100, 7'd15, 16'h1234, EXP_QNAN, 4'b0000});
        v.push_back('{16'h7c00, 16'h0000, 16'h3c00, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 2'b01, 3'b000, 7'd15, 16'h1234, 16'h7e00, 4'b1000});
        v.push_back('{16'h7c00, 16'h3c00, 16'hfc00, 3'b001, 3'b000, 3'b000, 3'b101, 3'b000, 2'b01, 3'b000, 7'd15, 16'h1234, 16'h7e00, 4'b1000});
        v.push_back('{16'hfc00, 16'h3c00, 16'h3c00, 3'b100, 3'b000, 3'b000, 3'b100, 3'b000, 2'b01, 3'b010, 7'd15, 16'h1234, 16'hfc00, 4'b0000});
        v.push_back('{16'h3c00, 16'h3c00, 16'hfc00, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 2'b01, 3'b000, 7'd15, 16'h1234, 16'hfc00, 4'b0000});
        v.push_back('{16'h7c00, 16'h3c00, 16'h7c00, 3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 2'b01, 3'b000, 7'd15, 16'h1234, 16'h7c00, 4'b0000});
        bus.out_ready = 1'b1;
        foreach (v[i]) begin
            apply(v[i]);
            send();
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL special_valid[%0d] got %b exp 1", i, bus.out_valid); end
            checks++;
            if (bus.out_result !== v[i].exp_res) begin errors++; $display("FAIL special_result[%0d] got %h exp %h", i, bus.out_result, v[i].exp_res); end
            checks++;
            if (bus.out_flags !== v[i].exp_flags) begin errors++; $display("FAIL special_flags[%0d] got %b exp %b", i, bus.out_flags, v[i].exp_flags); end
            checks++;
        end
        tick();
    endtask

    task automatic test_overflow();
        vec_t v[$];
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00, 3'b000, 7'd31, 16'h7bff, 16'h7bff, 4'b0101});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b000, 7'd31, 16'h7bff, 16'h7c00, 4'b0101});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b11, 3'b000, 7'd31, 16'h7bff, 16'h7c00, 4'b0101});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b10, 3'b000, 7'd40, 16'h7bff, 16'h7bff, 4'b0101});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b11, 3'b000, 7'd31, 16'hfbff, 16'hfbff, 4'b0101});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b10, 3'b000, 7'd31, 16'hfbff, 16'hfc00, 4'b0101});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00, 3'b000, 7'd31, 16'hfbff, 16'hfbff, 4'b0101});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b000, 7'd30, 16'h7bff, 16'h7bff, 4'b0000});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b000, 7'h40, 16'h0001, 16'h0001, 4'b0000});
        bus.out_ready = 1'b1;
        foreach (v[i]) begin
            apply(v[i]);
            send();
            if (bus.out_result !== v[i].exp_res) begin errors++; $display("FAIL ovf_result[%0d] got %h exp %h", i, bus.out_result, v[i].exp_res); end
            checks++;
            if (bus.out_flags !== v[i].exp_flags) begin errors++; $display("FAIL ovf_flags[%0d] got %b exp %b", i, bus.out_flags, v[i].exp_flags); end
            checks++;
        end
        tick();
    endtask

    task automatic test_underflow();
        vec_t v[$];
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b100, 7'd0, 16'h0001, 16'h0001, 4'b0011});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b000, 7'd0, 16'h0001, 16'h0001, 4'b0000});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b010, 7'h7e, 16'h0002, 16'h0002, 4'b0011});
        v.push_back('{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b001, 7'd1, 16'h0400, 16'h0400, 4'b0001});
        bus.out_ready = 1'b1;
        foreach (v[i]) begin
            apply(v[i]);
            send();
            if (bus.out_result !== v[i].exp_res) begin errors++; $display("FAIL uf_result[%0d] got %h exp %h", i, bus.out_result, v[i].exp_res); end
            checks++;
            if (bus.out_flags !== v[i].exp_flags) begin errors++; $display("FAIL uf_flags[%0d] got %b exp %b", i, bus.out_flags, v[i].exp_flags); end
            checks++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        vec_t a;
        vec_t b;
        a = '{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00, 3'b000, 7'd31, 16'h7bff, 16'h7bff, 4'b0101};
        b = '{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b100, 7'd0, 16'h0001, 16'h0001, 4'b0011};
        do_reset();
        bus.out_ready = 1'b0;
        apply(a);
        send();
        apply(b);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", c, bus.in_ready); end
            checks++;
            if (bus.out_result !== 16'h7bff || bus.out_flags !== 4'b0101) begin
                errors++; $display("FAIL stall_hold[%0d] got %h/%b exp 7bff/0101", c, bus.out_result, bus.out_flags);
            end
            checks++;
            if (bus.acc_flags !== 4'b0000) begin errors++; $display("FAIL stall_acc[%0d] got %b exp 0000", c, bus.acc_flags); end
            checks++;
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0001 || bus.out_flags !== 4'b0011) begin
            errors++; $display("FAIL b2b_second got %b/%h/%b exp 1/0001/0011", bus.out_valid, bus.out_result, bus.out_flags);
        end
        checks++;
        if (bus.acc_flags !== 4'b0101) begin errors++; $display("FAIL b2b_acc_first got %b exp 0101", bus.acc_flags); end
        checks++;
        tick();
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.acc_flags !== 4'b0111) begin errors++; $display("FAIL b2b_acc_both got %b exp 0111", bus.acc_flags); end
        checks++;
    endtask

    task automatic test_clear_fire();
        vec_t s;
        vec_t n;
        s = '{16'h7d00, 16'h3c00, 16'h0000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001, 2'b01, 3'b000, 7'd0, 16'h0000, EXP_SNAN, 4'b1000};
        n = '{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b100, 7'd1, 16'h3c00, 16'h3c00, 4'b0001};
        do_reset();
        bus.out_ready = 1'b1;
        apply(s);
        send();
        apply(n);
        send();
        if (bus.acc_flags !== 4'b1000) begin errors++; $display("FAIL clr_acc_before got %b exp 1000", bus.acc_flags); end
        checks++;
        if (bus.out_flags !== 4'b0001) begin errors++; $display("FAIL clr_pending_flags got %b exp 0001", bus.out_flags); end
        checks++;
        bus.flags_clr = 1'b1;
        tick();
        bus.flags_clr = 1'b0;
        if (bus.acc_flags !== 4'b0001) begin errors++; $display("FAIL clr_with_fire got %b exp 0001", bus.acc_flags); end
        checks++;
        bus.flags_clr = 1'b1;
        tick();
        bus.flags_clr = 1'b0;
        if (bus.acc_flags !== 4'b0000) begin errors++; $display("FAIL clr_idle got %b exp 0000", bus.acc_flags); end
        checks++;
    endtask

    task automatic test_reset_stall();
        vec_t s;
        vec_t o;
        s = '{16'h7d00, 16'h3c00, 16'h0000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001, 2'b01, 3'b000, 7'd0, 16'h0000, EXP_SNAN, 4'b1000};
        o = '{16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 3'b000, 7'd31, 16'h7bff, 16'h7c00, 4'b0101};
        bus.out_ready = 1'b1;
        apply(s);
        send();
        tick();
        if (bus.acc_flags !== 4'b1000) begin errors++; $display("FAIL rst_stall_pre_acc got %b exp 1000", bus.acc_flags); end
        checks++;
        bus.out_ready = 1'b0;
        apply(o);
        send();
        tick();
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h7c00) begin
            errors++; $display("FAIL rst_stall_held got %b/%h exp 1/7c00", bus.out_valid, bus.out_result);
        end
        checks++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0000 || bus.out_flags !== 4'b0000 || bus.acc_flags !== 4'b0000) begin
            errors++; $display("FAIL rst_stall_clear got %b/%h/%b/%b exp 0/0000/0000/0000",
                               bus.out_valid, bus.out_result, bus.out_flags, bus.acc_flags);
        end
        checks++;
        bus.out_ready = 1'b1;
        tick();
        if (bus.acc_flags !== 4'b0000 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_stall_dropped got %b/%b exp 0000/0", bus.acc_flags, bus.out_valid);
        end
        checks++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_special();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_clear_fire();
        test_reset_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fma_flags_pipe.md
Name: fma_flags_pipe

Overview:
- Parametrised, pipelined successor to the FMA special-case/flag resolution stage.
- Takes the rounded mid-result, operand classification and normalisation data for one FMA operation.
- Produces the final IEEE-754 result and per-operation flags {nv,of,uf,nx} after one register stage with valid/ready handshake.
- Maintains a sticky accumulated-flags register (fflags-style) for the FPU CSR.

Parameters:
- NE, 5, exponent width (5 = binary16).
- NF, 10, fraction width; word width W = NE+NF+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  stage can accept
- x, y, z  in  W each  raw operands (NaN payload source)
- xs, ys, zs  in  1 each  operand signs
- snan, nan, inf, zero  in  3 each  class bits; bit2=X, bit1=Y, bit0=Z
- roundmode  in  2  00 RZ, 01 RNE, 10 RDN, 11 RUP
- sticky, guard, rnd  in  1 each  sticky, guard and round bits from normalisation
- senorm  in  NE+2  signed normalised biased exponent
- mid_result  in  W  rounded result before special-case override
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  W  final result
- out_flags  out  4  {nv,of,uf,nx} for this operation
- flags_clr  in  1  clear accumulated flags
- acc_flags  out  4  sticky OR of flags over all delivered results

Behaviour:
- Reset: out_valid=0, out_result=0, out_flags=0, acc_flags=0. Any in-flight result is discarded.
- in_ready = ~out_valid | out_ready. Accept when in_valid & in_ready. Latency is 1 cycle (result registered on the accept edge).
- While out_valid & ~out_ready, all outputs hold stable.
- qNaN = {0, all-ones exponent, 1, zeros}; for NE=5 this is 16'h7e00.
- Priority (first match wins):
  1. any snan: qNaN, nv=1.
  2. any nan: qNaN, nv=0.
  3. (infX|infY) & infZ & (xs^ys^zs): qNaN, nv=1.
  4. (infX & zeroY) | (zeroX & infY): qNaN, nv=1.
  5. infX|infY: {xs^ys, ones, 0}.
  6. infZ: {zs, ones, 0}.
  7. overflow: senorm >= 2^NE-1 and senorm non-negative.
  8. otherwise: mid_result.
- Overflow result, with s = mid_result[W-1]:
  - Infinity if roundmode=RNE, or RUP & ~s, or RDN & s.
  - Otherwise max finite {s, ones-1, all-ones fraction}; for NE=5 this is 0x7bff / 0xfbff.
  - of=1.
- nx = (sticky|guard|rnd|of) & ~(any inf|any nan|nv).
- uf = (senorm <= 0 signed) & (sticky|guard|rnd), and only in case 8.
- Accumulator update each cycle: acc_next = (flags_clr ? 0 : acc_flags) | (out_fire ? out_flags : 0), where out_fire = out_valid & out_ready.
  - Clear and fire in the same cycle: the firing flags survive.
  - Flags are accumulated on delivery, not on acceptance.
- Reset mid-stall: the held result is dropped and its flags are never accumulated.

Optional Feature:
- Macro FMA_FLAGS_NAN_PROPAGATE_EN.
- Defined: in cases 1–2 the result is the first NaN operand in X, Y, Z priority, with the quiet bit forced to 1 and sign and payload kept. nv is unchanged. Cases 3–4 still return canonical qNaN.
- Undefined: every NaN result is canonical qNaN.

Test Plan:
- x=7d00 (sNaN), y=3c00, z=0000, out_ready=1 -> next cycle out_result=7e00, out_flags=1000; with macro out_result=7f00.
- x=7c00, y=0000, z=3c00 -> 7e00, flags 1000. Then x=7c00, y=3c00, z=fc00 -> 7e00, flags 1000.
- mid_result=7bff, senorm=31, sign 0: RZ -> 7bff, flags 0101; RNE -> 7c00, 0101. With sign 1: RUP -> fbff; RDN -> fc00.
- senorm=0, sticky=1, mid_result=0001 -> 0001, flags 0011. Same with sticky=guard=rnd=0 -> flags 0000.
- Hold out_ready=0 for 3 cycles with a second input pending -> in_ready=0, out_result stable, acc_flags unchanged. Then release -> both results in order, acc_flags = OR of both.
- flags_clr asserted on the same cycle as an out_fire carrying 0001, with acc_flags=1000 beforehand -> acc_flags=0001. Assert reset during a stall -> all outputs 0.
